// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with prescaled tick and set handshake.
// Optional 12-hour mode with pm indicator: define TIME_12H_EN.
module bcd_time_counter #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [23:0] set_time,
  output logic [23:0] time_bcd,
  output logic        sec_wrap,
  output logic        min_wrap,
  output logic        day_wrap,
  output logic        set_err,
  output logic        pm
);

`ifdef TIME_12H_EN
  localparam logic [23:0] RST_TIME = 24'h120000;
`else
  localparam logic [23:0] RST_TIME = 24'h000000;
`endif
  localparam logic [7:0] DIV_M1 = 8'(TICK_DIV - 1);

  logic [7:0]  presc;
  logic [23:0] time_n;
  logic [3:0]  ss_u, ss_t, mm_u, mm_t, hh_u, hh_t;
  logic [3:0]  s0, s1, s2, s3, s4, s5;
  logic        accept, legal, adv;
  logic        p0, p1, p2, p3, p4;
  logic        c0, c1, c2, c3, c4, c5;
  logic        hh_last, day_end, pm_q;

  assign {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u} = time_bcd;
  assign {s5, s4, s3, s2, s1, s0} = set_time;

  assign accept = set_valid & set_ready;
  assign adv = tick_in & ~accept & (presc == DIV_M1);

`ifdef TIME_12H_EN
  assign hh_last = (hh_t == 4'd1) & (hh_u == 4'd2);
  assign day_end = (hh_t == 4'd1) & (hh_u == 4'd1) & pm_q;
  assign legal = (s0 <= 4'd9) & (s1 <= 4'd5)
               & (s2 <= 4'd9) & (s3 <= 4'd5)
               & (s4 <= 4'd9) & (s5 <= 4'd1)
               & ~((s5 == 4'd0) & (s4 == 4'd0))
               & ~((s5 == 4'd1) & (s4 > 4'd2));
`else
  assign hh_last = (hh_t == 4'd2) & (hh_u == 4'd3);
  assign day_end = hh_last;
  assign legal = (s0 <= 4'd9) & (s1 <= 4'd5)
               & (s2 <= 4'd9) & (s3 <= 4'd5)
               & (s4 <= 4'd9) & (s5 <= 4'd2)
               & ~((s5 == 4'd2) & (s4 > 4'd3));
`endif

  assign p0 = ss_u == 4'd9;
  assign p1 = ss_t == 4'd5;
  assign p2 = mm_u == 4'd9;
  assign p3 = mm_t == 4'd5;
  assign p4 = (hh_u == 4'd9) | hh_last;

  // Flat lookahead carries: G=0, Cin=adv
  assign c0 = adv;
  assign c1 = adv & p0;
  assign c2 = adv & p0 & p1;
  assign c3 = adv & p0 & p1 & p2;
  assign c4 = adv & p0 & p1 & p2 & p3;
  assign c5 = adv & p0 & p1 & p2 & p3 & p4;

  always_comb begin
    time_n = time_bcd;
    if (c0) time_n[3:0]   = p0 ? 4'd0 : ss_u + 4'd1;
    if (c1) time_n[7:4]   = p1 ? 4'd0 : ss_t + 4'd1;
    if (c2) time_n[11:8]  = p2 ? 4'd0 : mm_u + 4'd1;
    if (c3) time_n[15:12] = p3 ? 4'd0 : mm_t + 4'd1;
    if (c4) begin
      if (hh_last) begin
`ifdef TIME_12H_EN
        time_n[23:16] = 8'h01;
`else
        time_n[23:16] = 8'h00;
`endif
      end else begin
        time_n[19:16] = p4 ? 4'd0 : hh_u + 4'd1;
        if (c5) time_n[23:20] = hh_t + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_bcd  <= RST_TIME;
      presc     <= 8'd0;
      set_ready <= 1'b1;
      set_err   <= 1'b0;
      sec_wrap  <= 1'b0;
      min_wrap  <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      set_ready <= ~accept;
      set_err   <= accept & ~legal;
      sec_wrap  <= c2;
      min_wrap  <= c4;
      day_wrap  <= c4 & day_end;
      if (accept) begin
        if (legal) begin
          time_bcd <= set_time;
          presc    <= 8'd0;
        end
      end else if (tick_in) begin
        presc    <= adv ? 8'd0 : presc + 8'd1;
        time_bcd <= time_n;
      end
    end
  end

`ifdef TIME_12H_EN
  // pm flips when 11:59:59 rolls into 12:00:00
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pm_q <= 1'b0;
    else if (c4 & (hh_t == 4'd1) & (hh_u == 4'd1))
      pm_q <= ~pm_q;
  end
  assign pm = pm_q;
`else
  assign pm_q = 1'b0;
  assign pm = pm_q;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench: two DUTs (TICK_DIV 1 and 4) share stimulus and are
// checked against a seconds-of-day reference model.
module tb_bcd_time_counter;

  typedef struct packed {
    logic [23:0] t;
    logic sw, mw, dw, err, rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        set_valid = 1'b0;
  logic [23:0] set_time = '0;

  logic [23:0] ta, tb;
  logic rdya, swa, mwa, dwa, erra, pma;
  logic rdyb, swb, mwb, dwb, errb, pmb;

  int tests = 0;
  int fails = 0;

  exp_t qa[$];
  exp_t qb[$];

  int secs[2];
  int presc[2];
  bit rdy[2];

  always #5 clk = ~clk;

  bcd_time_counter #(.TICK_DIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in),
    .set_valid(set_valid), .set_ready(rdya), .set_time(set_time),
    .time_bcd(ta), .sec_wrap(swa), .min_wrap(mwa), .day_wrap(dwa),
    .set_err(erra), .pm(pma)
  );

  bcd_time_counter #(.TICK_DIV(4)) u_b (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in),
    .set_valid(set_valid), .set_ready(rdyb), .set_time(set_time),
    .time_bcd(tb), .sec_wrap(swb), .min_wrap(mwb), .day_wrap(dwb),
    .set_err(errb), .pm(pmb)
  );

  function automatic void cmp(string n, logic [23:0] a, logic [23:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  function automatic logic [23:0] to_bcd(int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int to_secs(logic [23:0] b);
    int h, m, x;
    h = int'(b[23:20]) * 10 + int'(b[19:16]);
    m = int'(b[15:12]) * 10 + int'(b[11:8]);
    x = int'(b[7:4]) * 10 + int'(b[3:0]);
    return h * 3600 + m * 60 + x;
  endfunction

  function automatic bit is_legal(logic [23:0] b);
    for (int k = 0; k < 6; k++)
      if (b[4*k +: 4] > 4'd9) return 1'b0;
    if (b[7:4] > 4'd5 || b[15:12] > 4'd5) return 1'b0;
    return (int'(b[23:20]) * 10 + int'(b[19:16])) <= 23;
  endfunction

  task automatic step(input int i, input int div, input bit r,
                      input bit t, input bit v, input logic [23:0] s,
                      output exp_t e);
    bit acc;
    e = '0;
    if (!r) begin
      secs[i] = 0;
      presc[i] = 0;
      rdy[i] = 1'b1;
    end else begin
      acc = v && rdy[i];
      if (acc) begin
        if (is_legal(s)) begin
          secs[i] = to_secs(s);
          presc[i] = 0;
        end else begin
          e.err = 1'b1;
        end
        rdy[i] = 1'b0;
      end else begin
        rdy[i] = 1'b1;
        if (t) begin
          if (presc[i] == div - 1) begin
            presc[i] = 0;
            secs[i] = (secs[i] + 1) % 86400;
            e.sw = (secs[i] % 60) == 0;
            e.mw = (secs[i] % 3600) == 0;
            e.dw = secs[i] == 0;
          end else begin
            presc[i]++;
          end
        end
      end
    end
    e.t = to_bcd(secs[i]);
    e.rdy = rdy[i];
  endtask

  task automatic cyc(input bit t, input bit v, input logic [23:0] s,
                     input bit r = 1'b1);
    exp_t ea, eb;
    @(negedge clk);
    tick_in = t;
    set_valid = v;
    set_time = s;
    rst_n = r;
    step(0, 1, r, t, v, s, ea);
    step(1, 4, r, t, v, s, eb);
    qa.push_back(ea);
    qb.push_back(eb);
    if (!r) begin
      #1;
      cmp("async_rst_time_a", ta, 24'h0);
      cmp("async_rst_time_b", tb, 24'h0);
      cmp("async_rst_ready_a", 24'(rdya), 24'h1);
      cmp("async_rst_pulses_b", {20'h0, swb, mwb, dwb, errb}, 24'h0);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      cmp("time_a", ta, e.t);
      cmp("flags_a", {19'h0, swa, mwa, dwa, erra, rdya},
          {19'h0, e.sw, e.mw, e.dw, e.err, e.rdy});
      cmp("pm_a", 24'(pma), 24'h0);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      cmp("time_b", tb, e.t);
      cmp("flags_b", {19'h0, swb, mwb, dwb, errb, rdyb},
          {19'h0, e.sw, e.mw, e.dw, e.err, e.rdy});
    end
  end

  initial begin
    logic [23:0] s;
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0);
    repeat (60) cyc(1, 0, '0);
    cyc(0, 0, '0);
    cyc(0, 1, 24'h235958);
    cyc(1, 0, '0);
    cyc(1, 0, '0);
    cyc(0, 0, '0);
    cyc(0, 1, 24'h196000);
    cyc(0, 1, 24'h196000);
    cyc(0, 0, '0);
    cyc(1, 1, 24'h120000);
    cyc(1, 0, '0);
    cyc(0, 0, '0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0);
    repeat (2) cyc(1, 0, '0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0);
    repeat (3) cyc(1, 0, '0);
    cyc(1, 0, '0);
    cyc(0, 0, '0);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 7)
        s = to_bcd(int'($urandom_range(0, 86399)));
      else
        s = 24'($urandom);
      if ($urandom_range(0, 19) == 0)
        s = 24'h235959 - 24'($urandom_range(0, 3));
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, s,
          $urandom_range(0, 99) != 0);
    end
    cyc(0, 0, '0);
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
